// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC latch, fixed-latency imem read, IR capture, PC advance
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 8,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               finish_signal,
  input  logic               fetch_req,
  input  logic               flush,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  output logic               pc_inc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t     state;
  // Counts down the remaining WAIT cycles; 4 bits covers latencies up to 15.
  logic [3:0] wait_cnt;

  // Fetch FSM: every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      imem_addr   <= '0;
      imem_rd     <= 1'b0;
      ir_out      <= '0;
      ir_valid    <= 1'b0;
      pc_inc      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      imem_rd  <= 1'b0;
      ir_valid <= 1'b0;
      pc_inc   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (finish_signal) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (fetch_req) begin
            state     <= S_ISSUE;
            imem_addr <= pc_addr;
            imem_rd   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            wait_cnt <= 4'(MEM_LAT - 1);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A flush in the capture cycle wins: the returning word is dropped.
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == 4'd0) begin
            ir_out      <= imem_rdata;
            ir_valid    <= 1'b1;
            pc_inc      <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          if (finish_signal) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
